// File: rtl/can_ifs_pkg.sv
// Shared definitions for the CAN interframe-space tracker: state encodings
// and default bit-length constants.
package can_ifs_pkg;

  typedef enum logic [2:0] {
    WAIT         = 3'd0,
    INTERMISSION = 3'd1,
    OVERLOAD     = 3'd2,
    SUSPEND      = 3'd3,
    BUS_IDLE     = 3'd4
  } ifs_state_e;

  localparam int INTERMISSION_BITS_DEF = 3;
  localparam int SUSPEND_BITS_DEF      = 8;

endpackage

// File: rtl/interframe_space.sv
// CAN interframe space tracker: intermission, optional suspend-transmission
// field (enabled by IFS_SUSPEND_TRANSMISSION_EN) and bus idle detection.
module interframe_space
  import can_ifs_pkg::*;
#(
  parameter int INTERMISSION_BITS = INTERMISSION_BITS_DEF,
  parameter int SUSPEND_BITS      = SUSPEND_BITS_DEF,
  parameter int OVLD_CNT_W        = 2
) (
  input  logic                  samplePoint,
  input  logic                  reset,
  input  logic                  canRX,
  input  logic                  eofDone,
  input  logic                  endOverload,
  input  logic                  endError,
  input  logic                  errorPassive,
  input  logic                  wasTransmitter,
  output logic                  isOverload,
  output logic                  startOfFrame,
  output logic                  busIdle,
  output logic                  inIntermission,
  output logic [OVLD_CNT_W-1:0] overloadCount
);

  localparam logic [3:0]            INT_LAST = 4'(INTERMISSION_BITS - 1);
  localparam logic [OVLD_CNT_W-1:0] OVLD_MAX = '1;

  ifs_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [OVLD_CNT_W-1:0] ovld_cnt_q, ovld_cnt_d;
  logic                  is_overload_q, is_overload_d;
  logic                  sof_q, sof_d;
  logic                  bus_idle_q, bus_idle_d;
  logic                  in_int_q, in_int_d;
  logic                  suspend_cond;
  logic                  frame_end;

`ifdef IFS_SUSPEND_TRANSMISSION_EN
  localparam logic [3:0] SUS_LAST = 4'(SUSPEND_BITS - 1);
  assign suspend_cond = errorPassive & wasTransmitter;
`else
  logic unused_suspend_inputs;
  assign unused_suspend_inputs = errorPassive ^ wasTransmitter;
  assign suspend_cond = 1'b0;
`endif

  assign frame_end = eofDone | endOverload | endError;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ovld_cnt_d = ovld_cnt_q;
    sof_d      = 1'b0;

    case (state_q)
      WAIT: begin
        if (frame_end) begin
          state_d   = INTERMISSION;
          bit_cnt_d = 4'd0;
        end
      end

      INTERMISSION: begin
        if (canRX) begin
          if (bit_cnt_q == INT_LAST) begin
            bit_cnt_d = 4'd0;
            state_d   = suspend_cond ? SUSPEND : BUS_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (bit_cnt_q == INT_LAST) begin
          // A dominant last intermission bit is taken as the next SOF.
          sof_d      = 1'b1;
          ovld_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          state_d = OVERLOAD;
          if (ovld_cnt_q != OVLD_MAX) begin
            ovld_cnt_d = ovld_cnt_q + 1'b1;
          end
        end
      end

      OVERLOAD: begin
        if (endOverload || endError) begin
          state_d   = INTERMISSION;
          bit_cnt_d = 4'd0;
        end
      end

`ifdef IFS_SUSPEND_TRANSMISSION_EN
      SUSPEND: begin
        if (canRX) begin
          if (bit_cnt_q == SUS_LAST) begin
            bit_cnt_d = 4'd0;
            state_d   = BUS_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          sof_d      = 1'b1;
          ovld_cnt_d = '0;
          state_d    = WAIT;
        end
      end
`endif

      BUS_IDLE: begin
        if (!canRX) begin
          sof_d      = 1'b1;
          ovld_cnt_d = '0;
          state_d    = WAIT;
        end
      end

      default: begin
        state_d   = WAIT;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  // Level outputs follow the next state so they change on the sampling edge.
  always_comb begin
    is_overload_d = (state_d == OVERLOAD);
    bus_idle_d    = (state_d == BUS_IDLE);
    in_int_d      = (state_d == INTERMISSION);
  end

  always_ff @(posedge samplePoint) begin
    if (reset) begin
      state_q       <= WAIT;
      bit_cnt_q     <= 4'd0;
      ovld_cnt_q    <= '0;
      is_overload_q <= 1'b0;
      sof_q         <= 1'b0;
      bus_idle_q    <= 1'b0;
      in_int_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ovld_cnt_q    <= ovld_cnt_d;
      is_overload_q <= is_overload_d;
      sof_q         <= sof_d;
      bus_idle_q    <= bus_idle_d;
      in_int_q      <= in_int_d;
    end
  end

  assign isOverload     = is_overload_q;
  assign startOfFrame   = sof_q;
  assign busIdle        = bus_idle_q;
  assign inIntermission = in_int_q;
  assign overloadCount  = ovld_cnt_q;

endmodule
